// File: rtl/sigma_delta_adc_pkg.sv
// sigma_delta_adc_pkg: shared audio-path constants and the sample saturation helper
package sigma_delta_adc_pkg;
  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'h80;
  // Only a full window of ones reaches 256; clamp it to full scale, keep the rest as-is
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [SAMPLE_W:0] v);
    return v[SAMPLE_W] ? '1 : v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/sigma_delta_adc_sync2.sv
// sync2: generic two-flop synchronizer with synchronous active-low reset
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;
  // Two-stage metastability filter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/sigma_delta_adc.sv
// sigma_delta_adc: first-order sigma-delta loop closure, boxcar decimator and hysteresis ear bit
module sigma_delta_adc
  import sigma_delta_adc_pkg::*;
#(
  parameter int                  DECIM_LOG2 = 8,
  parameter logic [SAMPLE_W-1:0] HYST_HI    = 8'h90,
  parameter logic [SAMPLE_W-1:0] HYST_LO    = 8'h70
) (
  input  logic                clkadc,
  input  logic                reset_n,
  input  logic                cmp_in,
  output logic                fb_out,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                ear
);
  localparam int SH = DECIM_LOG2 - 8;
  localparam logic [DECIM_LOG2-1:0] WIN_LAST = '1;
  logic                  cmp_s;
  logic                  fb_q;
  logic [DECIM_LOG2-1:0] win_q, win_d;
  logic [DECIM_LOG2:0]   acc_q, acc_d, total;
  logic [SAMPLE_W:0]     scaled;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic                  valid_q, valid_d, ear_q, ear_d, last;
  sync2 #(.W(1)) u_sync (
    .clk_i  (clkadc),
    .rst_ni (reset_n),
    .d_i    (cmp_in),
    .q_o    (cmp_s)
  );
  // Window counting, accumulate-and-dump, scaling and hysteresis decision
  always_comb begin
    last     = win_q == WIN_LAST;
    total    = acc_q + (DECIM_LOG2+1)'(fb_q);
    scaled   = (SAMPLE_W+1)'(total >> SH);
    win_d    = win_q + DECIM_LOG2'(1);
    acc_d    = last ? '0 : total;
    valid_d  = last;
    sample_d = last ? sat_sample(scaled) : sample_q;
    ear_d    = !last ? ear_q : sample_d >= HYST_HI ? 1'b1 : sample_d <= HYST_LO ? 1'b0 : ear_q;
  end
  // Loop feedback register plus decimator state; reset drops any partial window
  always_ff @(posedge clkadc) begin
    if (!reset_n) begin
      fb_q     <= 1'b0;
      win_q    <= '0;
      acc_q    <= '0;
      sample_q <= MIDSCALE;
      valid_q  <= 1'b0;
      ear_q    <= 1'b0;
    end else begin
      fb_q     <= cmp_s;
      win_q    <= win_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ear_q    <= ear_d;
    end
  end
  assign fb_out       = fb_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign ear          = ear_q;
endmodule

// File: tb/tb_sigma_delta_adc.sv
// tb_sigma_delta_adc: scoreboard bench for DECIM_LOG2 = 8 and 10 side by side
module tb_sigma_delta_adc;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmp_in = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] dens [9] = '{8'h80, 8'h95, 8'h85, 8'h6F, 8'h75, 8'h90, 8'h8F, 8'h70, 8'h71};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask
  function automatic logic [8:0] expect_out(input int ones, input int sh, input logic prev);
    int v = ones >> sh;
    logic [7:0] s;
    s = v > 255 ? 8'hFF : v[7:0];
    return {s >= 8'h90 ? 1'b1 : s <= 8'h70 ? 1'b0 : prev, s};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int DL = g ? 10 : 8;
    localparam int N = 1 << DL;
    logic fb, sv, ear;
    logic [7:0] smp;
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_fb = 1'b0;
    logic [8:0] m_exp = 9'h080;
    int m_cnt = 0, m_acc = 0;
    logic [8:0] q[$];
    sigma_delta_adc #(.DECIM_LOG2(DL)) u_dut (
      .clkadc       (clk),
      .reset_n      (reset_n),
      .cmp_in       (cmp_in),
      .fb_out       (fb),
      .sample       (smp),
      .sample_valid (sv),
      .ear          (ear)
    );
    always @(posedge clk) begin
      if (!reset_n) begin
        m_s1 <= 1'b0;
        m_s2 <= 1'b0;
        m_fb <= 1'b0;
        m_cnt <= 0;
        m_acc <= 0;
        m_exp <= 9'h080;
        q.delete();
      end else begin
        m_s1 <= cmp_in;
        m_s2 <= m_s1;
        m_fb <= m_s2;
        m_cnt <= (m_cnt + 1) % N;
        if (m_cnt == N - 1) begin
          q.push_back(expect_out(m_acc + int'(m_fb), DL - 8, m_exp[8]));
          m_exp <= expect_out(m_acc + int'(m_fb), DL - 8, m_exp[8]);
          m_acc <= 0;
        end else begin
          m_acc <= m_acc + int'(m_fb);
        end
      end
    end
    always @(negedge clk) begin
      check(g ? "fb_out10" : "fb_out8", fb, m_fb);
      check(g ? "valid10" : "valid8", sv, q.size() != 0);
      if (q.size() != 0) check(g ? "sample_ear10" : "sample_ear8", {ear, smp}, q.pop_front());
      else check(g ? "hold10" : "hold8", {ear, smp}, m_exp);
    end
  end
  task automatic drive(input logic r, input logic c);
    @(negedge clk);
    reset_n = r;
    cmp_in = c;
  endtask
  initial begin
    repeat (3) drive(1'b0, 1'b1);
    for (int i = 0; i < 3072; i++) drive(1'b1, 1'b1);
    for (int i = 0; i < 2048; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 2048; i++) drive(1'b1, i[0]);
    for (int w = 0; w < 9; w++)
      for (int p = 0; p < 256; p++) drive(1'b1, p >= 3 && p < 3 + int'(dens[w]));
    for (int p = 0; p < 100; p++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 3072; i++) drive(1'b1, 1'b1);
    @(negedge clk);
    #1;
    check("pending", gen_dut[0].q.size() + gen_dut[1].q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sigma_delta_adc.md
# sigma_delta_adc

First-order sigma-delta ADC front end for the audio path, the input-side counterpart of the sigma-delta DAC in the mixer. An external comparator (LVDS pair or Schmitt input) compares the analog input against an RC-integrated copy of `fb_out`. This block closes the loop, decimates the 1-bit stream with a boxcar counter into excess-128 8-bit samples, and derives a hysteresis-filtered `ear` bit for the tape-load path.

## Interface
Parameters:
- `DECIM_LOG2`, 8: log2 of decimation window length N; legal range 8..12.
- `HYST_HI`, 8'h90: `ear` rises when a sample is ≥ this value.
- `HYST_LO`, 8'h70: `ear` falls when a sample is ≤ this value; HYST_LO < HYST_HI.

Ports:
- `clkadc`, in, 1: single clock, same rate as `clkdac`.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `cmp_in`, in, 1: asynchronous comparator result, 1 = input above feedback.
- `fb_out`, out, 1: registered feedback bit to the RC integrator (pack into IOB).
- `sample`, out, 8: last decimated sample, excess-128 (8'h80 = mid-scale).
- `sample_valid`, out, 1: one-cycle strobe, `sample` updated this cycle.
- `ear`, out, 1: hysteresis-thresholded level.

## Operation
- `cmp_in` → two-flop synchronizer (`s1`, `s2`) → `fb_out` register. The loop bit is `fb_out`; its ones-density tracks input level.
- Window counter `win_cnt` (DECIM_LOG2 bits) increments every cycle and wraps N-1 → 0.
- Accumulator `acc` (DECIM_LOG2+1 bits) adds the current `fb_out` every cycle.
- On cycle with `win_cnt == N-1`: total = acc + fb_out (0..N); `sample` ← sat255(total >> (DECIM_LOG2-8)); `sample_valid` ← 1; `acc` ← 0. Otherwise `sample_valid` ← 0, `sample` holds.
- Saturation: only total == N can exceed 255; it maps to 8'hFF. Everything else truncates.
- `ear` update is evaluated only on the cycle `sample_valid` is 1, using the new `sample`: if ≥ HYST_HI → 1; if ≤ HYST_LO → 0; else hold.
- Reset (`reset_n` low at an edge): `s1`, `s2`, `fb_out` = 0; `win_cnt`, `acc` = 0; `sample` = 8'h80; `sample_valid` = 0; `ear` = 0. Reset mid-window discards the partial window. No `sample_valid` occurs until a full N cycles after release.

## Timing
- `cmp_in` → `fb_out`: 3 clock edges.
- Edge 0 is the first edge with `reset_n` high. `win_cnt` = 0 is accumulated at edge 0, and the first `sample_valid` is high in the cycle after edge N-1.
- `ear` changes in the same cycle as the `sample_valid` that caused it (both registered on the same edge).
- Sample rate = f(clkadc)/N. Back-to-back windows have no gap, and strobes are exactly N cycles apart.

## Structure
- Shared audio package: `SAMPLE_W` = 8 and `MIDSCALE` = 8'h80, also used by the mixer/DAC side.
- One sub-module: `sync2`, a generic 2-flop synchronizer with synchronous active-low reset. It is reusable for `ear`/`mic` pins elsewhere.
- The rest (window counter, accumulator, scaler, hysteresis) stays flat in `sigma_delta_adc`.

## Test plan
- `cmp_in` held 1, DECIM_LOG2=8 → first window `sample` = 253 (3-cycle pipeline fill); every later window 8'hFF (256 saturates); strobes every 256 cycles; `ear` = 1 after first strobe.
- `cmp_in` held 0 → every `sample` = 8'h00, `ear` stays 0, `fb_out` stays 0.
- `cmp_in` toggles every cycle → steady-state `sample` = 8'h80; `ear` holds 0 (inside hysteresis band).
- Force densities giving samples 8'h95, 8'h85, 8'h6F, 8'h75 in sequence → `ear` = 1, 1, 0, 0.
- Drop `reset_n` for 1 cycle at `win_cnt` = 100 → `sample` = 8'h80, `sample_valid` = 0, and the next strobe comes exactly 256 cycles after release.
- DECIM_LOG2=10, `cmp_in` held 1 → steady-state sample 8'hFF (1024>>2 saturated); with 512 ones per window → 8'h80.
